// File: rtl/kc_tap_loader_if.sv
// hps_io ioctl download stream plus the RAM write port used by the KC87 tape loader.
// master = loader side (consumes ioctl bytes, issues RAM writes), slave = environment side.
interface kc_tap_loader_if #(
  parameter int ADDR_W = 16
);
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_data;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_wr;
  logic              mem_ack;

  modport master (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_data, mem_ack,
    output ioctl_wait, mem_addr, mem_data, mem_wr
  );

  modport slave (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_data, mem_ack,
    input  ioctl_wait, mem_addr, mem_data, mem_wr
  );
endinterface

// File: rtl/kc_tap_loader.sv
// KC-TAPE (.tap) loader: checks the signature, parses 129-byte blocks and writes the payload to RAM.
// Define KC_TAP_AUTOSTART_EN to add a one-cycle autostart pulse when a load with exec address completes.
module kc_tap_loader #(
  parameter int ADDR_W    = 16,
  parameter int BLK_LEN   = 128,
  parameter int TAP_INDEX = 1,
  parameter int SIG_LEN   = 16
) (
  input  logic              clk,
  input  logic              reset,
  kc_tap_loader_if.master   bus,
  output logic              busy,
  output logic              load_done,
  output logic [2:0]        load_err,
  output logic [ADDR_W-1:0] exec_addr,
  output logic              exec_valid
`ifdef KC_TAP_AUTOSTART_EN
  ,output logic             autostart
`endif
);

  typedef enum logic [2:0] {IDLE, SIG, BLKNUM, HDR, DATA, WRITE, DONE, ERR} state_t;
  localparam int BC_W = $clog2(BLK_LEN + 1);

  state_t            state_q, state_d;
  logic              dl_prev_q;
  logic [24:0]       byte_cnt_q, byte_cnt_d;
  logic [BC_W-1:0]   blk_cnt_q, blk_cnt_d, blk_cnt_nx;
  logic              first_blk_q, first_blk_d;
  logic [7:0]        argc_q, argc_d;
  logic [15:0]       start_q, start_d, end_q, end_d, exec_q, exec_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, end_a;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              all_wr_q, all_wr_d;
  logic              done_q, done_d;
  logic [2:0]        err_q, err_d;
  logic              ev_q, ev_d;
  logic              start_dl, blk_last;
  logic [31:0]       hdr_pos;
  logic              unused_idx;

  function automatic logic [7:0] sig_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'hC3;
      4'd1:    return 8'h4B;
      4'd2:    return 8'h43;
      4'd3:    return 8'h2D;
      4'd4:    return 8'h54;
      4'd5:    return 8'h41;
      4'd6:    return 8'h50;
      4'd7:    return 8'h45;
      4'd8:    return 8'h20;
      4'd9:    return 8'h62;
      4'd10:   return 8'h79;
      4'd11:   return 8'h20;
      4'd12:   return 8'h41;
      4'd13:   return 8'h46;
      4'd14:   return 8'h2E;
      default: return 8'h20;
    endcase
  endfunction

  assign unused_idx = ^bus.ioctl_index[7:6];
  assign start_dl   = bus.ioctl_download && !dl_prev_q && (bus.ioctl_index[5:0] == 6'(TAP_INDEX));
  assign blk_cnt_nx = blk_cnt_q + BC_W'(1);
  assign blk_last   = (blk_cnt_nx == BC_W'(BLK_LEN));
  assign hdr_pos    = 32'(blk_cnt_q);
  assign end_a      = ADDR_W'(end_q);

  // A download that ends (level low) in any parsing state is judged by whether the whole range was written.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    blk_cnt_d   = blk_cnt_q;
    first_blk_d = first_blk_q;
    argc_d      = argc_q;
    start_d     = start_q;
    end_d       = end_q;
    exec_d      = exec_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    all_wr_d    = all_wr_q;
    done_d      = done_q;
    err_d       = err_q;
    ev_d        = ev_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_dl) begin
          state_d     = SIG;
          done_d      = 1'b0;
          err_d       = 3'd0;
          ev_d        = 1'b0;
          byte_cnt_d  = '0;
          all_wr_d    = 1'b0;
          first_blk_d = 1'b1;
        end
      end
      WRITE: begin
        if (bus.mem_ack) begin
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          if (mem_addr_q == end_a) all_wr_d = 1'b1;
          state_d = (blk_cnt_q == BC_W'(BLK_LEN)) ? BLKNUM : DATA;
        end
      end
      default: begin
        if (!bus.ioctl_download) begin
          if (all_wr_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 3'd4;
          end
        end else if (bus.ioctl_wr) begin
          byte_cnt_d = byte_cnt_q + 25'd1;
          if (bus.ioctl_addr != byte_cnt_q) begin
            state_d = ERR;
            err_d   = 3'd5;
          end else begin
            case (state_q)
              SIG: begin
                if (bus.ioctl_data != sig_byte(byte_cnt_q[3:0])) begin
                  state_d = ERR;
                  err_d   = 3'd1;
                end else if (byte_cnt_q == 25'(SIG_LEN - 1)) begin
                  state_d = BLKNUM;
                end
              end
              BLKNUM: begin
                blk_cnt_d   = '0;
                first_blk_d = 1'b0;
                state_d     = first_blk_q ? HDR : DATA;
              end
              HDR: begin
                blk_cnt_d = blk_cnt_nx;
                case (hdr_pos)
                  32'd16:  argc_d        = bus.ioctl_data;
                  32'd17:  start_d[7:0]  = bus.ioctl_data;
                  32'd18:  start_d[15:8] = bus.ioctl_data;
                  32'd19:  end_d[7:0]    = bus.ioctl_data;
                  32'd20:  end_d[15:8]   = bus.ioctl_data;
                  32'd21:  exec_d[7:0]   = bus.ioctl_data;
                  32'd22:  exec_d[15:8]  = bus.ioctl_data;
                  default: ;
                endcase
                if (blk_last) begin
                  if (argc_q < 8'd2) begin
                    state_d = ERR;
                    err_d   = 3'd2;
                  end else if (end_q < start_q) begin
                    state_d = ERR;
                    err_d   = 3'd3;
                  end else begin
                    mem_addr_d = ADDR_W'(start_q);
                    ev_d       = (argc_q >= 8'd3);
                    state_d    = BLKNUM;
                  end
                end
              end
              DATA: begin
                blk_cnt_d = blk_cnt_nx;
                if (mem_addr_q <= end_a) begin
                  mem_data_d = bus.ioctl_data;
                  state_d    = WRITE;
                end else if (blk_last) begin
                  state_d = BLKNUM;
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dl_prev_q   <= 1'b0;
      byte_cnt_q  <= '0;
      blk_cnt_q   <= '0;
      first_blk_q <= 1'b0;
      argc_q      <= '0;
      start_q     <= '0;
      end_q       <= '0;
      exec_q      <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      all_wr_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 3'd0;
      ev_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_prev_q   <= bus.ioctl_download;
      byte_cnt_q  <= byte_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
      first_blk_q <= first_blk_d;
      argc_q      <= argc_d;
      start_q     <= start_d;
      end_q       <= end_d;
      exec_q      <= exec_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      all_wr_q    <= all_wr_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ev_q        <= ev_d;
    end
  end

`ifdef KC_TAP_AUTOSTART_EN
  logic autostart_q, autostart_d;

  always_comb autostart_d = (state_d == DONE) && (state_q != DONE) && ev_q;

  always_ff @(posedge clk) begin
    if (reset) autostart_q <= 1'b0;
    else       autostart_q <= autostart_d;
  end

  assign autostart = autostart_q;
`endif

  assign bus.ioctl_wait = (state_q == WRITE);
  assign bus.mem_wr     = (state_q == WRITE);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_data   = mem_data_q;
  assign busy           = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
  assign load_done      = done_q;
  assign load_err       = err_q;
  assign exec_valid     = ev_q;
  assign exec_addr      = ADDR_W'(exec_q);

endmodule

// File: tb/tb_kc_tap_loader.sv
// Randomised self-checking bench for kc_tap_loader: builds .tap images, streams them as hps_io would,
// acknowledges RAM writes with a programmable delay and compares against a file-level reference model.
module tb_kc_tap_loader;

  localparam int TAP_IDX = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy, load_done, exec_valid;
  logic [2:0]  load_err;
  logic [15:0] exec_addr;

  kc_tap_loader_if #(.ADDR_W(16)) bus();

`ifdef KC_TAP_AUTOSTART_EN
  logic autostart;
  int   as_pulses = 0, as_wide = 0;
  logic as_prev = 1'b0;
`endif

  kc_tap_loader #(.ADDR_W(16), .BLK_LEN(128), .TAP_INDEX(TAP_IDX), .SIG_LEN(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .exec_addr  (exec_addr),
    .exec_valid (exec_valid)
`ifdef KC_TAP_AUTOSTART_EN
    ,.autostart (autostart)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0]  sig_rom [16] = '{8'hC3, 8'h4B, 8'h43, 8'h2D, 8'h54, 8'h41, 8'h50, 8'h45,
                                8'h20, 8'h62, 8'h79, 8'h20, 8'h41, 8'h46, 8'h2E, 8'h20};
  logic [7:0]  file_q[$], payload_q[$];
  logic [15:0] got_a_q[$], exp_a_q[$];
  logic [7:0]  got_d_q[$], exp_d_q[$];
  logic [2:0]  exp_err;
  logic        exp_done, exp_ev;
  logic [15:0] exp_ea = 16'h0000;
  int          ack_delay = 2, stall_viol = 0;
  bit          busy_seen = 0, wait_seen = 0, resp_abort;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // RAM side: acknowledge each write after ack_delay cycles, logging what was written.
  initial begin
    bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_wr && !reset) begin
        resp_abort = 0;
        for (int i = 0; i < ack_delay; i++) begin
          if (!bus.ioctl_wait) stall_viol++;
          @(negedge clk);
          if (!bus.mem_wr || reset) begin resp_abort = 1; break; end
        end
        if (!resp_abort) begin
          if (!bus.ioctl_wait) stall_viol++;
          got_a_q.push_back(bus.mem_addr);
          got_d_q.push_back(bus.mem_data);
          bus.mem_ack = 1'b1;
          @(negedge clk);
          bus.mem_ack = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (busy) busy_seen = 1;
      if (bus.ioctl_wait) wait_seen = 1;
`ifdef KC_TAP_AUTOSTART_EN
      if (autostart && !as_prev) as_pulses++;
      if (autostart && as_prev) as_wide++;
      as_prev = autostart;
`endif
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  task automatic buildFile(input logic [7:0] argc, input logic [15:0] st, input logic [15:0] en,
                           input logic [15:0] ex);
    logic [7:0] b;
    file_q.delete();
    for (int i = 0; i < 16; i++) file_q.push_back(sig_rom[i]);
    file_q.push_back(8'h01);
    for (int j = 0; j < 128; j++) begin
      case (j)
        16:      b = argc;
        17:      b = st[7:0];
        18:      b = st[15:8];
        19:      b = en[7:0];
        20:      b = en[15:8];
        21:      b = ex[7:0];
        22:      b = ex[15:8];
        default: b = 8'h20;
      endcase
      file_q.push_back(b);
    end
    for (int k = 0; k < payload_q.size(); k += 128) begin
      file_q.push_back(8'(2 + k / 128));
      for (int j = 0; j < 128; j++)
        file_q.push_back((k + j < payload_q.size()) ? payload_q[k + j] : 8'hFF);
    end
  endtask

  // File-level model: signature, header rules, then payload byte k lands at start+k while start+k <= end.
  task automatic modelRun(input int n);
    logic [7:0]  argc;
    logic [15:0] st, en;
    int k;
    exp_a_q.delete(); exp_d_q.delete();
    exp_err = 3'd0; exp_done = 1'b0; exp_ev = 1'b0;
    for (int i = 0; i < 16 && i < n; i++)
      if (file_q[i] !== sig_rom[i]) begin exp_err = 3'd1; return; end
    if (n >= 40) exp_ea = {file_q[39], file_q[38]};
    if (n < 145) begin exp_err = 3'd4; return; end
    argc = file_q[33];
    st   = {file_q[35], file_q[34]};
    en   = {file_q[37], file_q[36]};
    if (argc < 8'd2) begin exp_err = 3'd2; return; end
    if (en < st) begin exp_err = 3'd3; return; end
    exp_ev = (argc >= 8'd3);
    k = 0;
    for (int off = 145; off < n; off++) begin
      if ((off - 145) % 129 == 0) continue;
      if (k <= int'(en) - int'(st)) begin
        exp_a_q.push_back(16'(int'(st) + k));
        exp_d_q.push_back(file_q[off]);
      end
      k++;
    end
    if (exp_a_q.size() == int'(en) - int'(st) + 1) exp_done = 1'b1;
    else exp_err = 3'd4;
  endtask

  // Streams the first n bytes of file_q, honouring ioctl_wait; optionally pokes a stray ioctl_wr
  // into each stall, corrupts the offset of byte bad_at, or resets the DUT at the first write.
  task automatic applyStimulus(input int n, input int dly, input bit inject, input bit rst_at_wr,
                               input int bad_at, input logic [7:0] idx);
    int budget;
    bit injected;
    ack_delay = dly;
    @(negedge clk);
    bus.ioctl_index = idx;
    bus.ioctl_download = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      budget = 0;
      injected = 0;
      while (bus.ioctl_wait && budget < 200) begin
        if (inject && !injected) begin
          bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(i); bus.ioctl_data = 8'hEE;
          injected = 1;
          @(negedge clk);
          bus.ioctl_wr = 1'b0;
        end else begin
          @(negedge clk);
        end
        budget++;
      end
      if (budget >= 200) begin checkOutput("wait_timeout", 32'(0), 32'(1)); break; end
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(i + ((i == bad_at) ? 1 : 0));
      bus.ioctl_data = file_q[i];
      @(negedge clk);
      bus.ioctl_wr = 1'b0;
      if (rst_at_wr && bus.mem_wr) begin
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst.mem_wr", 32'(bus.mem_wr), 32'(0));
        checkOutput("rst.ioctl_wait", 32'(bus.ioctl_wait), 32'(0));
        checkOutput("rst.busy", 32'(busy), 32'(0));
        checkOutput("rst.load_done", 32'(load_done), 32'(0));
        checkOutput("rst.load_err", 32'(load_err), 32'(0));
        checkOutput("rst.exec_valid", 32'(exec_valid), 32'(0));
        checkOutput("rst.exec_addr", 32'(exec_addr), 32'(0));
        reset = 1'b0;
        bus.ioctl_download = 1'b0;
        exp_ea = 16'h0000;
        repeat (4) @(negedge clk);
        return;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.ioctl_download = 1'b0;
    @(negedge clk);
    budget = 0;
    while (busy && budget < 400) begin @(negedge clk); budget++; end
    if (budget >= 400) checkOutput("busy_timeout", 32'(0), 32'(1));
    repeat (3) @(negedge clk);
  endtask

  task automatic runAndCheck(input string tag, input int n, input int dly, input bit inject,
                             input int bad_at);
    got_a_q.delete(); got_d_q.delete();
    stall_viol = 0;
`ifdef KC_TAP_AUTOSTART_EN
    as_pulses = 0; as_wide = 0;
`endif
    applyStimulus(n, dly, inject, 0, bad_at, 8'(TAP_IDX));
    modelRun((bad_at >= 0 && bad_at < n) ? bad_at : n);
    if (bad_at >= 0 && bad_at < n && (exp_err == 3'd0 || exp_err == 3'd4)) begin
      exp_err = 3'd5; exp_done = 1'b0;
    end
    checkOutput({tag, ".writes"}, 32'(got_a_q.size()), 32'(exp_a_q.size()));
    for (int i = 0; i < exp_a_q.size() && i < got_a_q.size(); i++) begin
      checkOutput($sformatf("%s.addr%0d", tag, i), 32'(got_a_q[i]), 32'(exp_a_q[i]));
      checkOutput($sformatf("%s.data%0d", tag, i), 32'(got_d_q[i]), 32'(exp_d_q[i]));
    end
    checkOutput({tag, ".load_done"}, 32'(load_done), 32'(exp_done));
    checkOutput({tag, ".load_err"}, 32'(load_err), 32'(exp_err));
    checkOutput({tag, ".exec_valid"}, 32'(exec_valid), 32'(exp_ev));
    checkOutput({tag, ".exec_addr"}, 32'(exec_addr), 32'(exp_ea));
    checkOutput({tag, ".stall_wait"}, 32'(stall_viol), 32'(0));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(0));
`ifdef KC_TAP_AUTOSTART_EN
    checkOutput({tag, ".autostart"}, 32'(as_pulses), 32'((exp_done && exp_ev) ? 1 : 0));
    checkOutput({tag, ".autostart_w"}, 32'(as_wide), 32'(0));
`endif
  endtask

  task automatic validPayload();
    payload_q.delete();
    for (int i = 0; i < 4; i++) payload_q.push_back(8'(8'hA0 + i));
    for (int i = 4; i < 128; i++) payload_q.push_back(8'h55);
  endtask

  initial begin
    bus.ioctl_download = 1'b0; bus.ioctl_index = 8'h00; bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0; bus.ioctl_data = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset.mem_wr", 32'(bus.mem_wr), 32'(0));
    checkOutput("reset.ioctl_wait", 32'(bus.ioctl_wait), 32'(0));
    checkOutput("reset.busy", 32'(busy), 32'(0));
    checkOutput("reset.load_done", 32'(load_done), 32'(0));
    checkOutput("reset.load_err", 32'(load_err), 32'(0));
    checkOutput("reset.exec_valid", 32'(exec_valid), 32'(0));
    checkOutput("reset.mem_addr", 32'(bus.mem_addr), 32'(0));
    checkOutput("reset.mem_data", 32'(bus.mem_data), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    validPayload();
    buildFile(8'd3, 16'h0300, 16'h0303, 16'h0300);
    runAndCheck("valid", file_q.size(), 2, 0, -1);
    checkOutput("valid.exec_addr_abs", 32'(exec_addr), 32'h0300);

    file_q[4] = 8'h58;
    busy_seen = 0;
    runAndCheck("badsig", file_q.size(), 2, 0, -1);
    checkOutput("badsig.load_err_abs", 32'(load_err), 32'(1));

    buildFile(8'd3, 16'h0300, 16'h0200, 16'h0300);
    runAndCheck("endlt", file_q.size(), 2, 0, -1);
    checkOutput("endlt.load_err_abs", 32'(load_err), 32'(3));

    buildFile(8'd1, 16'h0300, 16'h0303, 16'h0300);
    runAndCheck("argc1", file_q.size(), 2, 0, -1);

    buildFile(8'd3, 16'h0300, 16'h0303, 16'h0300);
    runAndCheck("trunc", 145 + 1 + 2, 2, 0, -1);
    checkOutput("trunc.load_err_abs", 32'(load_err), 32'(4));

    runAndCheck("stall", file_q.size(), 20, 1, -1);
    runAndCheck("badaddr", file_q.size(), 1, 0, 20);

    got_a_q.delete();
    applyStimulus(file_q.size(), 20, 0, 1, -1, 8'(TAP_IDX));
    checkOutput("rst.no_write", 32'(got_a_q.size()), 32'(0));

    busy_seen = 0; wait_seen = 0; got_a_q.delete();
    applyStimulus(file_q.size(), 2, 0, 0, -1, 8'd2);
    checkOutput("idx2.busy_seen", 32'(busy_seen), 32'(0));
    checkOutput("idx2.wait_seen", 32'(wait_seen), 32'(0));
    checkOutput("idx2.writes", 32'(got_a_q.size()), 32'(0));
    checkOutput("idx2.load_done", 32'(load_done), 32'(0));

    for (int it = 0; it < 6; it++) begin
      int len, n;
      logic [15:0] st;
      len = int'($urandom_range(1, 200));
      st  = 16'($urandom_range(0, 16'hF000));
      payload_q.delete();
      for (int i = 0; i < len + int'($urandom_range(0, 60)); i++) payload_q.push_back(8'($urandom));
      buildFile(8'($urandom_range(2, 4)), st, 16'(int'(st) + len - 1), 16'($urandom));
      n = file_q.size();
      if ($urandom_range(0, 2) == 0) n = int'($urandom_range(146, file_q.size()));
      runAndCheck($sformatf("rand%0d", it), n, int'($urandom_range(0, 3)), 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
